alu_seq_loader: RTL and testbench
=================================

// Module: alu_seq_loader
// PURPOSE
//  Parametrised successor to the switch/button ALU top level. Loads operands A and B and an opcode from board
//  switches via edge-detected buttons, through an ordered FSM. Operands may be wider than the switch bank
//  (chunked loads). Registers result, flags and valid/error; allows re-execution with a new opcode. Board top level.
// PARAMETERS
//  NB_DATA_BUS  8  operand/result width; must be integer multiple of NB_SWITCH
//  NB_SWITCH    8  switch bank width (chunk size per button press)
//  NB_OPCODE    6  opcode width (taken from i_switch[NB_OPCODE-1:0])
//  NB_DBG_LED   2  state debug LED width
// PORTS
//  i_clock    in   1             system clock, rising edge
//  i_btnU     in   1             reset, synchronous, active-high
//  i_switch   in   NB_SWITCH     data/opcode input
//  i_btnL     in   1             load A chunk
//  i_btnC     in   1             load B chunk
//  i_btnR     in   1             load opcode and execute
//  o_led      out  NB_DATA_BUS   registered result
//  o_flags    out  3             {carry, zero, overflow}, registered with o_led
//  o_valid    out  1             result valid
//  o_err      out  1             last opcode unsupported
//  o_led_dbg  out  NB_DBG_LED    FSM state code
// BEHAVIOUR
//  - Reset: o_led=0, o_flags=0, o_valid=0, o_err=0, A=B=0, chunk count=0, state=LOAD_A (code 0). Reset wins over any press.
//  - Buttons: two-flop sample per button; edge = q1 & ~q2. Only one edge per press, however long it is held.
//  - States/codes: LOAD_A=0, LOAD_B=1, LOAD_OP=2, DONE=3.
//    LOAD_A: each btnL edge shifts i_switch into A, LSB chunk first (A <= {sw, A[top:NB_SWITCH]}).
//      After NB_DATA_BUS/NB_SWITCH chunks -> LOAD_B, count cleared.
//    LOAD_B: same with btnC into B -> LOAD_OP.
//    LOAD_OP: btnR edge latches opcode, computes, registers result -> DONE; o_valid=1.
//    DONE: btnR edge re-executes with new opcode and same A/B; stays in DONE.
//      btnL edge clears o_valid, loads first chunk of new A, goes to LOAD_A (count=1; if 1 chunk total -> LOAD_B).
//  - Edges for a button not accepted in the current state are ignored. Simultaneous edges: only the
//    state's own button acts.
//  - Latency: btnR first sampled high at edge k -> o_led/o_flags/o_valid updated at edge k+2.
//  - o_led_dbg holds the state code. If NB_DBG_LED > 2, upper bits are 0.
//  - Opcodes:
//    ADD=100000  A+B
//    SUB=100010  A-B
//    AND=100100
//    OR=100101
//    XOR=100110
//    NOR=100111
//    SRA=000011  A>>>B, sign fill
//    SRL=000010  A>>B, zero fill
//  - Shifts: if B >= NB_DATA_BUS, SRL=0 and SRA=all sign bits.
//  - Widths: arithmetic is NB_DATA_BUS+1 bits.
//    carry = ADD carry-out; for SUB, borrow (A<B unsigned); 0 for other ops.
//    overflow = signed overflow for ADD/SUB, else 0.
//    zero = (o_led == 0).
//  - Unsupported opcode: o_led=0, flags=0, o_err=1, o_valid=1. Any valid execute clears o_err.
//  - Reset mid-load or mid-DONE discards partial operands; no partial result is ever flagged valid.
// TESTING
//  1. 8-bit ADD: A=0xA0, B=0x0A, op=0x20 -> o_led=0xAA, flags=000, o_valid=1 two edges after btnR.
//  2. 8-bit SUB: 0x70-0x30 -> 0x40, carry=0. Then in DONE, op=0x22 with A=0x30,B=0x70 (new load) -> 0xC0, carry(borrow)=1.
//  3. 8-bit overflow and shifts:
//     0x7F+0x01 -> 0x80, ovf=1.
//     SRA 0x8B by 2 -> 0xE2.
//     SRL 0xA0 by 4 -> 0x0A.
//     SRL by 9 -> 0x00.
//  4. NB_DATA_BUS=16: btnL with 0x34 then 0x12, btnC with 0x01 then 0x00, op ADD -> 0x1235.
//     o_led_dbg steps 0,0,1,1,2,3.
//  5. Order and hold: btnC/btnR in LOAD_A ignored (state stays 0). btnL held 20 cycles loads once.
//     Op 0x3F -> o_err=1, o_led=0.
//  6. Reset in LOAD_B after A loaded -> all outputs 0, state 0. Next full sequence gives a correct result.

Source files
------------

// File: rtl/alu_seq_loader_if.sv
// Board-side bundle for the sequential ALU loader: switch bank and buttons in, result/status out.
// Latency: none, wires only.
// Backpressure: none; buttons are edge events and presses in a non-accepting state are dropped.
interface alu_seq_loader_if #(
    parameter int NB_DATA_BUS = 8,
    parameter int NB_SWITCH   = 8,
    parameter int NB_DBG_LED  = 2
);
    logic [NB_SWITCH-1:0]   i_switch;
    logic                   i_btnL;
    logic                   i_btnC;
    logic                   i_btnR;
    logic [NB_DATA_BUS-1:0] o_led;
    logic [2:0]             o_flags;
    logic                   o_valid;
    logic                   o_err;
    logic [NB_DBG_LED-1:0]  o_led_dbg;

    // Board / stimulus side.
    modport master (
        output i_switch, i_btnL, i_btnC, i_btnR,
        input  o_led, o_flags, o_valid, o_err, o_led_dbg
    );

    // Loader side.
    modport slave (
        input  i_switch, i_btnL, i_btnC, i_btnR,
        output o_led, o_flags, o_valid, o_err, o_led_dbg
    );
endinterface

// File: rtl/alu_seq_loader.sv
// Loads A, B (chunked from the switch bank) and an opcode via edge-detected buttons, then executes.
// Latency: btnR first sampled high at edge k -> result, flags and valid registered at edge k+2.
// Backpressure: none; presses for a button the current state does not own are ignored.
module alu_seq_loader #(
    parameter int NB_DATA_BUS = 8,
    parameter int NB_SWITCH   = 8,
    parameter int NB_OPCODE   = 6,
    parameter int NB_DBG_LED  = 2
) (
    input  logic             i_clock,
    input  logic             i_btnU,
    alu_seq_loader_if.slave  bus
);
    localparam int NCHUNK = NB_DATA_BUS / NB_SWITCH;
    localparam int CW     = $clog2(NCHUNK) + 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);
    localparam logic [NB_DATA_BUS:0] NB_LIM = (NB_DATA_BUS + 1)'(NB_DATA_BUS);
    localparam int T = NB_DATA_BUS - 1;

    localparam logic [NB_OPCODE-1:0] OP_ADD = NB_OPCODE'(6'b100000);
    localparam logic [NB_OPCODE-1:0] OP_SUB = NB_OPCODE'(6'b100010);
    localparam logic [NB_OPCODE-1:0] OP_AND = NB_OPCODE'(6'b100100);
    localparam logic [NB_OPCODE-1:0] OP_OR  = NB_OPCODE'(6'b100101);
    localparam logic [NB_OPCODE-1:0] OP_XOR = NB_OPCODE'(6'b100110);
    localparam logic [NB_OPCODE-1:0] OP_NOR = NB_OPCODE'(6'b100111);
    localparam logic [NB_OPCODE-1:0] OP_SRA = NB_OPCODE'(6'b000011);
    localparam logic [NB_OPCODE-1:0] OP_SRL = NB_OPCODE'(6'b000010);

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        LOAD_OP = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] btn_q1, btn_q2, btn_edge;   // {R, C, L}
    logic edge_l, edge_c, edge_r;
    logic ld_a, ld_b, ld_op, clr_valid, exec_q;

    logic [NB_DATA_BUS-1:0] a_q, b_q;
    logic [NB_OPCODE-1:0]   op_q;
    logic [NB_DATA_BUS+NB_SWITCH-1:0] a_cat, b_cat;

    logic [NB_DATA_BUS:0]   sum, diff;
    logic [NB_DATA_BUS-1:0] res;
    logic                   res_c, res_v, res_err, b_big;

    logic [NB_DATA_BUS-1:0] led_q;
    logic [2:0]             flags_q;
    logic                   valid_q, err_q;

    // Two-flop button sampling; one edge per press regardless of hold time.
    always_ff @(posedge i_clock) begin
        if (i_btnU) begin
            btn_q1 <= '0;
            btn_q2 <= '0;
        end else begin
            btn_q1 <= {bus.i_btnR, bus.i_btnC, bus.i_btnL};
            btn_q2 <= btn_q1;
        end
    end

    assign btn_edge = btn_q1 & ~btn_q2;
    assign edge_l   = btn_edge[0];
    assign edge_c   = btn_edge[1];
    assign edge_r   = btn_edge[2];

    // State and chunk-count registers.
    always_ff @(posedge i_clock) begin
        if (i_btnU) begin
            state_q <= LOAD_A;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and load strobes; in DONE a re-execute takes priority over a new load.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ld_a      = 1'b0;
        ld_b      = 1'b0;
        ld_op     = 1'b0;
        clr_valid = 1'b0;
        case (state_q)
            LOAD_A: if (edge_l) begin
                ld_a = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = LOAD_B;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            LOAD_B: if (edge_c) begin
                ld_b = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = LOAD_OP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            LOAD_OP: if (edge_r) begin
                ld_op   = 1'b1;
                state_d = DONE;
            end
            DONE: if (edge_r) begin
                ld_op = 1'b1;
            end else if (edge_l) begin
                ld_a      = 1'b1;
                clr_valid = 1'b1;
                if (LAST == '0) begin
                    state_d = LOAD_B;
                    cnt_d   = '0;
                end else begin
                    state_d = LOAD_A;
                    cnt_d   = CW'(1);
                end
            end
            default: begin
                state_d = LOAD_A;
                cnt_d   = '0;
            end
        endcase
    end

    // Chunks enter at the top and walk down, so the first chunk ends up least significant.
    assign a_cat = {bus.i_switch, a_q};
    assign b_cat = {bus.i_switch, b_q};

    assign sum   = {1'b0, a_q} + {1'b0, b_q};
    assign diff  = {1'b0, a_q} - {1'b0, b_q};
    assign b_big = ({1'b0, b_q} >= NB_LIM);

    // Result and flags from the latched opcode and operands.
    always_comb begin
        res     = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        res_err = 1'b0;
        case (op_q)
            OP_ADD: begin
                res   = sum[T:0];
                res_c = sum[NB_DATA_BUS];
                res_v = (a_q[T] == b_q[T]) && (sum[T] != a_q[T]);
            end
            OP_SUB: begin
                res   = diff[T:0];
                res_c = diff[NB_DATA_BUS];
                res_v = (a_q[T] != b_q[T]) && (diff[T] != a_q[T]);
            end
            OP_AND: res = a_q & b_q;
            OP_OR:  res = a_q | b_q;
            OP_XOR: res = a_q ^ b_q;
            OP_NOR: res = ~(a_q | b_q);
            OP_SRA: res = b_big ? {NB_DATA_BUS{a_q[T]}} : NB_DATA_BUS'($signed(a_q) >>> b_q);
            OP_SRL: res = b_big ? '0 : (a_q >> b_q);
            default: res_err = 1'b1;
        endcase
    end

    // Operand/opcode capture and registered outputs; a new A load wins over a same-cycle result.
    always_ff @(posedge i_clock) begin
        if (i_btnU) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            exec_q  <= 1'b0;
            led_q   <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (ld_a)  a_q  <= a_cat[NB_DATA_BUS+NB_SWITCH-1:NB_SWITCH];
            if (ld_b)  b_q  <= b_cat[NB_DATA_BUS+NB_SWITCH-1:NB_SWITCH];
            if (ld_op) op_q <= bus.i_switch[NB_OPCODE-1:0];
            exec_q <= ld_op;
            if (exec_q) begin
                led_q   <= res;
                flags_q <= {res_c, ~res_err && (res == '0), res_v};
                valid_q <= 1'b1;
                err_q   <= res_err;
            end
            if (clr_valid) valid_q <= 1'b0;
        end
    end

    assign bus.o_led     = led_q;
    assign bus.o_flags   = flags_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_err     = err_q;
    assign bus.o_led_dbg = NB_DBG_LED'(state_q);
endmodule

// File: tb/tb_alu_seq_loader.sv
// Bench for alu_seq_loader: 8-bit and 16-bit instances, directed cases plus randomized ALU vectors.
// Latency: checks the k+2 execute latency explicitly, other checks sample after presses settle.
// Backpressure: none; stimulus is button presses with switch values held across each press.
module tb_alu_seq_loader;
    typedef struct packed {
        logic       err;
        logic [2:0] flags;
        logic [7:0] led;
    } res_t;

    logic tb_i_clock = 1'b0;
    logic tb_rst;
    int   n_vec = 0;
    int   n_mis = 0;
    logic [7:0] last_a, last_b;

    always #5 tb_i_clock = ~tb_i_clock;

    alu_seq_loader_if #(.NB_DATA_BUS(8),  .NB_SWITCH(8), .NB_DBG_LED(2)) bus8();
    alu_seq_loader_if #(.NB_DATA_BUS(16), .NB_SWITCH(8), .NB_DBG_LED(2)) bus16();

    alu_seq_loader #(.NB_DATA_BUS(8), .NB_SWITCH(8), .NB_OPCODE(6), .NB_DBG_LED(2)) dut8 (
        .i_clock (tb_i_clock),
        .i_btnU  (tb_rst),
        .bus     (bus8)
    );

    alu_seq_loader #(.NB_DATA_BUS(16), .NB_SWITCH(8), .NB_OPCODE(6), .NB_DBG_LED(2)) dut16 (
        .i_clock (tb_i_clock),
        .i_btnU  (tb_rst),
        .bus     (bus16)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge tb_i_clock);
        #1;
    endtask

    // d selects the instance (8 or 16); btn 0=L, 1=C, 2=R.
    task automatic press(input int d, input int btn, input logic [7:0] sw, input int hold);
        if (d == 8) begin
            bus8.i_switch = sw;
            bus8.i_btnL = (btn == 0);
            bus8.i_btnC = (btn == 1);
            bus8.i_btnR = (btn == 2);
        end else begin
            bus16.i_switch = sw;
            bus16.i_btnL = (btn == 0);
            bus16.i_btnC = (btn == 1);
            bus16.i_btnR = (btn == 2);
        end
        cyc(hold);
        bus8.i_btnL = 1'b0;  bus8.i_btnC = 1'b0;  bus8.i_btnR = 1'b0;
        bus16.i_btnL = 1'b0; bus16.i_btnC = 1'b0; bus16.i_btnR = 1'b0;
        cyc(3);
    endtask

    // Reference ALU on plain integers.
    function automatic res_t ref8(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        res_t r;
        int ai, bi, sa, sb, t;
        ai = int'(a);
        bi = int'(b);
        sa = (ai >= 128) ? ai - 256 : ai;
        sb = (bi >= 128) ? bi - 256 : bi;
        r  = '0;
        t  = 0;
        case (op)
            6'h20: begin
                t = ai + bi;
                r.led = t[7:0];
                r.flags[2] = (t > 255);
                r.flags[0] = ((sa + sb) > 127) || ((sa + sb) < -128);
            end
            6'h22: begin
                t = ai - bi;
                r.led = t[7:0];
                r.flags[2] = (ai < bi);
                r.flags[0] = ((sa - sb) > 127) || ((sa - sb) < -128);
            end
            6'h24: r.led = a & b;
            6'h25: r.led = a | b;
            6'h26: r.led = a ^ b;
            6'h27: r.led = ~(a | b);
            6'h03: begin
                if (bi >= 8) r.led = (sa < 0) ? 8'hFF : 8'h00;
                else begin
                    t = sa >>> bi;
                    r.led = t[7:0];
                end
            end
            6'h02: begin
                t = (bi >= 8) ? 0 : (ai >> bi);
                r.led = t[7:0];
            end
            default: r.err = 1'b1;
        endcase
        r.flags[1] = !r.err && (r.led == 8'h00);
        return r;
    endfunction

    task automatic chk_res(input string tag, input res_t e);
        chk({tag, ".led"},   32'(bus8.o_led),     32'(e.led));
        chk({tag, ".flags"}, 32'(bus8.o_flags),   32'(e.flags));
        chk({tag, ".err"},   32'(bus8.o_err),     32'(e.err));
        chk({tag, ".valid"}, 32'(bus8.o_valid),   32'd1);
        chk({tag, ".dbg"},   32'(bus8.o_led_dbg), 32'd3);
    endtask

    // Full A, B, opcode sequence on the 8-bit instance (from LOAD_A or DONE).
    task automatic run_vec(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [5:0] op, input int hold);
        press(8, 0, a, hold);
        chk({tag, ".dbgA"},  32'(bus8.o_led_dbg), 32'd1);
        chk({tag, ".vclr"},  32'(bus8.o_valid),   32'd0);
        press(8, 1, b, hold);
        chk({tag, ".dbgB"},  32'(bus8.o_led_dbg), 32'd2);
        press(8, 2, {2'b00, op}, hold);
        last_a = a;
        last_b = b;
        chk_res(tag, ref8(a, b, op));
    endtask

    task automatic reexec(input string tag, input logic [5:0] op, input int hold);
        press(8, 2, {2'b00, op}, hold);
        chk_res(tag, ref8(last_a, last_b, op));
    endtask

    initial begin
        logic [5:0] ops [8];
        logic [7:0] ra, rb;
        logic [5:0] rop;
        int k;
        ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
        bus8.i_switch = '0;  bus8.i_btnL = 0;  bus8.i_btnC = 0;  bus8.i_btnR = 0;
        bus16.i_switch = '0; bus16.i_btnL = 0; bus16.i_btnC = 0; bus16.i_btnR = 0;
        tb_rst = 1'b1;
        cyc(3);
        tb_rst = 1'b0;
        cyc(1);

        // Reset state of both instances.
        chk("rst.led",   32'(bus8.o_led),      32'd0);
        chk("rst.flags", 32'(bus8.o_flags),    32'd0);
        chk("rst.valid", 32'(bus8.o_valid),    32'd0);
        chk("rst.err",   32'(bus8.o_err),      32'd0);
        chk("rst.dbg",   32'(bus8.o_led_dbg),  32'd0);
        chk("rst16.dbg", 32'(bus16.o_led_dbg), 32'd0);
        chk("rst16.led", 32'(bus16.o_led),     32'd0);

        // Out-of-order buttons in LOAD_A are ignored.
        press(8, 1, 8'h11, 1);
        press(8, 2, 8'h20, 1);
        chk("ign.dbg",   32'(bus8.o_led_dbg), 32'd0);
        chk("ign.valid", 32'(bus8.o_valid),   32'd0);

        // ADD with explicit k+2 latency.
        press(8, 0, 8'hA0, 2);
        press(8, 1, 8'h0A, 2);
        bus8.i_switch = 8'h20;
        bus8.i_btnR = 1'b1;
        cyc(1);
        chk("lat.k",   32'(bus8.o_valid), 32'd0);
        cyc(1);
        chk("lat.k1",  32'(bus8.o_valid), 32'd0);
        cyc(1);
        chk("lat.k2",  32'(bus8.o_valid), 32'd1);
        chk("add.led", 32'(bus8.o_led),   32'hAA);
        chk("add.flg", 32'(bus8.o_flags), 32'd0);
        bus8.i_btnR = 1'b0;
        cyc(3);

        // SUB, then new load from DONE with borrow.
        run_vec("sub1", 8'h70, 8'h30, 6'h22, 1);
        chk("sub1.const", 32'(bus8.o_led), 32'h40);
        run_vec("sub2", 8'h30, 8'h70, 6'h22, 2);
        chk("sub2.const",  32'(bus8.o_led),      32'hC0);
        chk("sub2.borrow", 32'(bus8.o_flags[2]), 32'd1);

        // Overflow and shifts.
        run_vec("ovf", 8'h7F, 8'h01, 6'h20, 1);
        chk("ovf.const", 32'(bus8.o_flags[0]), 32'd1);
        run_vec("sra", 8'h8B, 8'h02, 6'h03, 1);
        chk("sra.const", 32'(bus8.o_led), 32'hE2);
        run_vec("srl", 8'hA0, 8'h04, 6'h02, 1);
        chk("srl.const", 32'(bus8.o_led), 32'h0A);
        reexec("sra.re", 6'h03, 1);
        run_vec("srl9", 8'hFF, 8'h09, 6'h02, 1);
        chk("srl9.const", 32'(bus8.o_led), 32'h00);
        reexec("sra9", 6'h03, 1);
        chk("sra9.const", 32'(bus8.o_led), 32'hFF);
        run_vec("subovf", 8'h80, 8'h01, 6'h22, 1);

        // 16-bit chunked load and state walk.
        chk("w16.d0", 32'(bus16.o_led_dbg), 32'd0);
        press(16, 0, 8'h34, 1);
        chk("w16.d1", 32'(bus16.o_led_dbg), 32'd0);
        press(16, 0, 8'h12, 2);
        chk("w16.d2", 32'(bus16.o_led_dbg), 32'd1);
        press(16, 1, 8'h01, 1);
        chk("w16.d3", 32'(bus16.o_led_dbg), 32'd1);
        press(16, 1, 8'h00, 1);
        chk("w16.d4", 32'(bus16.o_led_dbg), 32'd2);
        press(16, 2, 8'h20, 1);
        chk("w16.d5",  32'(bus16.o_led_dbg), 32'd3);
        chk("w16.led", 32'(bus16.o_led),     32'h1235);
        chk("w16.flg", 32'(bus16.o_flags),   32'd0);
        chk("w16.vld", 32'(bus16.o_valid),   32'd1);

        // Long hold from DONE loads exactly one chunk; unsupported opcode.
        press(16, 0, 8'h55, 20);
        chk("hold.dbg", 32'(bus16.o_led_dbg), 32'd0);
        chk("hold.vld", 32'(bus16.o_valid),   32'd0);
        press(16, 0, 8'h00, 1);
        chk("hold.dbg2", 32'(bus16.o_led_dbg), 32'd1);
        press(16, 1, 8'h02, 1);
        press(16, 1, 8'h00, 1);
        press(16, 2, 8'h3F, 1);
        chk("bad.err", 32'(bus16.o_err),   32'd1);
        chk("bad.led", 32'(bus16.o_led),   32'd0);
        chk("bad.flg", 32'(bus16.o_flags), 32'd0);
        chk("bad.vld", 32'(bus16.o_valid), 32'd1);
        press(16, 2, 8'h20, 1);
        chk("fix.err", 32'(bus16.o_err), 32'd0);
        chk("fix.led", 32'(bus16.o_led), 32'h0057);

        // Reset mid-load, with a button held, discards everything.
        press(8, 0, 8'h99, 1);
        chk("mid.dbg", 32'(bus8.o_led_dbg), 32'd1);
        tb_rst = 1'b1;
        bus8.i_btnC = 1'b1;
        cyc(2);
        chk("mrst.led",   32'(bus8.o_led),     32'd0);
        chk("mrst.flags", 32'(bus8.o_flags),   32'd0);
        chk("mrst.valid", 32'(bus8.o_valid),   32'd0);
        chk("mrst.err",   32'(bus8.o_err),     32'd0);
        chk("mrst.dbg",   32'(bus8.o_led_dbg), 32'd0);
        bus8.i_btnC = 1'b0;
        cyc(1);
        tb_rst = 1'b0;
        cyc(3);
        chk("mrst.dbg2", 32'(bus8.o_led_dbg), 32'd0);
        run_vec("post", 8'h05, 8'h03, 6'h20, 1);
        chk("post.const", 32'(bus8.o_led), 32'h08);

        // Randomized vectors against the reference model.
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom);
            k  = $urandom_range(0, 8);
            rop = (k == 8) ? 6'($urandom) : ops[k];
            run_vec($sformatf("rnd%0d", i), ra, rb, rop, $urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, 7);
                reexec($sformatf("rre%0d", i), ops[k], $urandom_range(1, 3));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
